// File: rtl/axi_cmd_master.sv
// Single-outstanding AXI master: turns one local read/write command into one AXI
// transaction and returns the result on a valid/ready response port.
module axi_cmd_master #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [ID_W-1:0]     wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [DATA_W/8-1:0] rstrb_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o
);
    localparam int STRB_W = DATA_W / 8;
    // Abort fires on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] TO_LAST = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

    state_t              state, state_d;
    logic                aw_vld, aw_vld_d, w_vld, w_vld_d, ar_vld, ar_vld_d;
    logic                b_rdy, b_rdy_d, r_rdy, r_rdy_d;
    logic                wr_q, wr_d, wlast_q, wlast_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdat_q, rdat_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          resp_q, resp_d;
    logic [15:0]         wdog, wdog_d;
    logic                busy, expire, adv;

    logic unused_inputs;
    assign unused_inputs = ^{bid_i, rid_i, rstrb_i, rlast_i};

    assign busy   = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_DATA);
    assign expire = (TIMEOUT != 0) && busy && (wdog == TO_LAST);

    always_comb begin
        state_d  = state;
        aw_vld_d = aw_vld;
        w_vld_d  = w_vld;
        ar_vld_d = ar_vld;
        b_rdy_d  = b_rdy;
        r_rdy_d  = r_rdy;
        wr_d     = wr_q;
        wlast_d  = wlast_q;
        id_d     = id_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdat_d   = rdat_q;
        resp_d   = resp_q;
        wdog_d   = busy ? wdog + 16'd1 : wdog;
        adv      = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                wr_d    = cmd_write;
                id_d    = cmd_id;
                addr_d  = cmd_addr;
                wdata_d = cmd_wdata;
                wstrb_d = cmd_wstrb;
                wlast_d = cmd_write;
                wdog_d  = '0;
                if (cmd_write) begin
                    aw_vld_d = 1'b1;
                    w_vld_d  = 1'b1;
                    state_d  = WR_REQ;
                end else begin
                    ar_vld_d = 1'b1;
                    state_d  = RD_REQ;
                end
            end
            WR_REQ: begin
                if (aw_vld && awready_i) aw_vld_d = 1'b0;
                if (w_vld && wready_i)   w_vld_d  = 1'b0;
                // AW and W may complete in either order or together.
                if ((!aw_vld || awready_i) && (!w_vld || wready_i)) begin
                    b_rdy_d = 1'b1;
                    state_d = WR_RESP;
                    adv     = 1'b1;
                end
            end
            WR_RESP: if (bvalid_i) begin
                resp_d  = bresp_i;
                rdat_d  = '0;
                b_rdy_d = 1'b0;
                state_d = RSP;
                adv     = 1'b1;
            end
            RD_REQ: if (arready_i) begin
                ar_vld_d = 1'b0;
                r_rdy_d  = 1'b1;
                state_d  = RD_DATA;
                adv      = 1'b1;
            end
            RD_DATA: if (rvalid_i) begin
                rdat_d  = rdata_i;
                resp_d  = 2'b00;
                r_rdy_d = 1'b0;
                state_d = RSP;
                adv     = 1'b1;
            end
            RSP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A completing handshake in the expiry cycle takes priority over the abort.
        if (expire && !adv) begin
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
            ar_vld_d = 1'b0;
            b_rdy_d  = 1'b0;
            r_rdy_d  = 1'b0;
            resp_d   = 2'b11;
            rdat_d   = '0;
            state_d  = RSP;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state   <= IDLE;
            aw_vld  <= 1'b0;
            w_vld   <= 1'b0;
            ar_vld  <= 1'b0;
            b_rdy   <= 1'b0;
            r_rdy   <= 1'b0;
            wr_q    <= 1'b0;
            wlast_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdat_q  <= '0;
            resp_q  <= '0;
            wdog    <= '0;
        end else begin
            state   <= state_d;
            aw_vld  <= aw_vld_d;
            w_vld   <= w_vld_d;
            ar_vld  <= ar_vld_d;
            b_rdy   <= b_rdy_d;
            r_rdy   <= r_rdy_d;
            wr_q    <= wr_d;
            wlast_q <= wlast_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdat_q  <= rdat_d;
            resp_q  <= resp_d;
            wdog    <= wdog_d;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign rsp_write = wr_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rdat_q;
    assign rsp_resp  = resp_q;
    assign awid_o    = id_q;
    assign awaddr_o  = addr_q;
    assign awvalid_o = aw_vld;
    assign wid_o     = id_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wlast_o   = wlast_q;
    assign wvalid_o  = w_vld;
    assign bready_o  = b_rdy;
    assign arid_o    = id_q;
    assign araddr_o  = addr_q;
    assign arvalid_o = ar_vld;
    assign rready_o  = r_rdy;
endmodule

// File: tb/tb_axi_cmd_master.sv
// Directed bench for axi_cmd_master: cycle-exact slave stimulus, TIMEOUT=8.
module tb_axi_cmd_master;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, SW = DATA_W / 8, TO = 8;

    logic clk = 1'b0, areset;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [ID_W-1:0] cmd_id, rsp_id, awid_o, wid_o, bid_i, arid_o, rid_i;
    logic [ADDR_W-1:0] cmd_addr, awaddr_o, araddr_o;
    logic [DATA_W-1:0] cmd_wdata, rsp_data, wdata_o, rdata_i;
    logic [SW-1:0] cmd_wstrb, wstrb_o, rstrb_i;
    logic rsp_valid, rsp_ready, rsp_write;
    logic [1:0] rsp_resp, bresp_i;
    logic awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
    logic arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

    int checks = 0, failures = 0, b_hs = 0, rsp_hs = 0;

    axi_cmd_master #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rstrb_i(rstrb_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bvalid_i && bready_o) b_hs++;
        if (rsp_valid && rsp_ready) rsp_hs++;
    end

    task automatic cyc; @(posedge clk); #1; endtask
    task automatic smp; @(negedge clk); endtask

    task automatic send(input logic wr, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    endtask

    task automatic test_reset;
        areset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_wdata = 0;
        cmd_wstrb = 0; rsp_ready = 0; awready_i = 0; wready_i = 0; bid_i = 0; bresp_i = 0;
        bvalid_i = 0; arready_i = 0; rid_i = 0; rdata_i = 0; rstrb_i = 0; rlast_i = 0; rvalid_i = 0;
        cyc; cyc; smp;
        checks++; if ({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid, cmd_ready} !== 7'b0000001) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000001", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid, cmd_ready}); end
        checks++; if ({awid_o, awaddr_o, wdata_o, wstrb_o, wlast_o, rsp_id, rsp_data, rsp_resp, rsp_write} !== '0) begin
            failures++; $display("FAIL reset_payload got=%h exp=0", {awid_o, awaddr_o, wdata_o, wstrb_o, wlast_o, rsp_id, rsp_data, rsp_resp, rsp_write}); end
        cyc; areset = 1'b0; smp;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_write;
        awready_i = 1; wready_i = 1;
        cyc; send(1'b1, 4'd5, 32'd3, 32'hDEADBEEF, 4'hF); smp;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_cmd_ready got=%b exp=1", cmd_ready); end
        cyc; cmd_valid = 0; smp;
        checks++; if ({awvalid_o, wvalid_o, wlast_o, cmd_ready, rsp_valid} !== 5'b11100) begin
            failures++; $display("FAIL wr_req_flags got=%b exp=11100", {awvalid_o, wvalid_o, wlast_o, cmd_ready, rsp_valid}); end
        checks++; if ({awid_o, wid_o, awaddr_o, wdata_o, wstrb_o} !== {4'd5, 4'd5, 32'd3, 32'hDEADBEEF, 4'hF}) begin
            failures++; $display("FAIL wr_req_payload got=%h exp=%h", {awid_o, wid_o, awaddr_o, wdata_o, wstrb_o}, {4'd5, 4'd5, 32'd3, 32'hDEADBEEF, 4'hF}); end
        cyc; bvalid_i = 1; bresp_i = 2'b00; smp;
        checks++; if ({awvalid_o, wvalid_o, bready_o, rsp_valid} !== 4'b0010) begin
            failures++; $display("FAIL wr_resp_flags got=%b exp=0010", {awvalid_o, wvalid_o, bready_o, rsp_valid}); end
        cyc; bvalid_i = 0; rsp_ready = 1; smp;
        checks++; if ({rsp_valid, bready_o, rsp_write, rsp_id, rsp_resp, rsp_data} !== {1'b1, 1'b0, 1'b1, 4'd5, 2'b00, 32'd0}) begin
            failures++; $display("FAIL wr_rsp got=%h exp=%h", {rsp_valid, bready_o, rsp_write, rsp_id, rsp_resp, rsp_data}, {1'b1, 1'b0, 1'b1, 4'd5, 2'b00, 32'd0}); end
        cyc; rsp_ready = 0; smp;
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL wr_back_idle got=%b exp=10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_skewed_write;
        int b0, r0;
        b0 = b_hs; r0 = rsp_hs;
        cyc; send(1'b1, 4'd6, 32'h10, 32'h12345678, 4'h3); awready_i = 0; wready_i = 1; smp;
        cyc; cmd_valid = 0; smp;
        checks++; if ({awvalid_o, wvalid_o} !== 2'b11) begin failures++; $display("FAIL skew_c1 got=%b exp=11", {awvalid_o, wvalid_o}); end
        for (int k = 0; k < 3; k++) begin
            cyc; if (k == 2) awready_i = 1; smp;
            checks++; if ({awvalid_o, wvalid_o, awaddr_o} !== {2'b10, 32'h10}) begin
                failures++; $display("FAIL skew_hold%0d got=%h exp=%h", k, {awvalid_o, wvalid_o, awaddr_o}, {2'b10, 32'h10}); end
        end
        cyc; bvalid_i = 1; bresp_i = 2'b10; smp;
        checks++; if ({awvalid_o, bready_o, rsp_valid} !== 3'b010) begin
            failures++; $display("FAIL skew_b got=%b exp=010", {awvalid_o, bready_o, rsp_valid}); end
        cyc; bvalid_i = 0; rsp_ready = 1; smp;
        checks++; if ({rsp_valid, bready_o, rsp_resp, rsp_id, rsp_data} !== {2'b10, 2'b10, 4'd6, 32'd0}) begin
            failures++; $display("FAIL skew_rsp got=%h exp=%h", {rsp_valid, bready_o, rsp_resp, rsp_id, rsp_data}, {2'b10, 2'b10, 4'd6, 32'd0}); end
        cyc; rsp_ready = 0; smp;
        checks++; if ((b_hs - b0) != 1 || (rsp_hs - r0) != 1) begin
            failures++; $display("FAIL skew_counts got=b%0d/r%0d exp=b1/r1", b_hs - b0, rsp_hs - r0); end
    endtask

    task automatic test_read;
        arready_i = 1;
        cyc; send(1'b0, 4'd7, 32'd3, 32'd0, 4'h0); smp;
        cyc; cmd_valid = 0; smp;
        checks++; if ({arvalid_o, arid_o, araddr_o, awvalid_o} !== {1'b1, 4'd7, 32'd3, 1'b0}) begin
            failures++; $display("FAIL rd_ar got=%h exp=%h", {arvalid_o, arid_o, araddr_o, awvalid_o}, {1'b1, 4'd7, 32'd3, 1'b0}); end
        cyc; smp;
        checks++; if ({arvalid_o, rready_o} !== 2'b01) begin failures++; $display("FAIL rd_rready got=%b exp=01", {arvalid_o, rready_o}); end
        cyc; smp;
        cyc; rvalid_i = 1; rdata_i = 32'hDEADBEEF; smp;
        checks++; if ({rready_o, rsp_valid} !== 2'b10) begin failures++; $display("FAIL rd_wait got=%b exp=10", {rready_o, rsp_valid}); end
        cyc; rvalid_i = 0; rdata_i = 0; smp;
        checks++; if ({rsp_valid, rready_o, rsp_write, rsp_id, rsp_resp, rsp_data} !== {3'b100, 4'd7, 2'b00, 32'hDEADBEEF}) begin
            failures++; $display("FAIL rd_rsp got=%h exp=%h", {rsp_valid, rready_o, rsp_write, rsp_id, rsp_resp, rsp_data}, {3'b100, 4'd7, 2'b00, 32'hDEADBEEF}); end
    endtask

    // Continues from the read response left pending by test_read.
    task automatic test_backpressure;
        for (int k = 0; k < 5; k++) begin
            cyc; send(1'b1, 4'd9, 32'd4, 32'hA5A50001, 4'hF); smp;
            checks++; if ({cmd_ready, rsp_valid, rsp_id, rsp_data} !== {2'b01, 4'd7, 32'hDEADBEEF}) begin
                failures++; $display("FAIL bp_hold%0d got=%h exp=%h", k, {cmd_ready, rsp_valid, rsp_id, rsp_data}, {2'b01, 4'd7, 32'hDEADBEEF}); end
        end
        cyc; rsp_ready = 1; smp;
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", cmd_ready); end
        cyc; rsp_ready = 0; smp;
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin failures++; $display("FAIL bp_accept got=%b exp=10", {cmd_ready, rsp_valid}); end
        cyc; cmd_valid = 0; awready_i = 1; wready_i = 1; smp;
        checks++; if ({awvalid_o, awid_o, wdata_o} !== {1'b1, 4'd9, 32'hA5A50001}) begin
            failures++; $display("FAIL bp_next_aw got=%h exp=%h", {awvalid_o, awid_o, wdata_o}, {1'b1, 4'd9, 32'hA5A50001}); end
        cyc; bvalid_i = 1; bresp_i = 2'b00; smp;
        cyc; bvalid_i = 0; rsp_ready = 1; smp;
        checks++; if ({rsp_valid, rsp_write, rsp_id, rsp_resp} !== {2'b11, 4'd9, 2'b00}) begin
            failures++; $display("FAIL bp_next_rsp got=%h exp=%h", {rsp_valid, rsp_write, rsp_id, rsp_resp}, {2'b11, 4'd9, 2'b00}); end
        cyc; rsp_ready = 0;
    endtask

    task automatic test_timeout;
        int b0, r0;
        r0 = rsp_hs;
        cyc; send(1'b1, 4'd3, 32'h40, 32'h1, 4'h1); awready_i = 1; wready_i = 1; smp;
        for (int k = 1; k <= TO; k++) begin
            cyc; cmd_valid = 0; smp;
            checks++; if (rsp_valid !== 1'b0 || (k >= 2 && bready_o !== 1'b1)) begin
                failures++; $display("FAIL to_busy%0d got=%b%b exp=01", k, rsp_valid, bready_o); end
        end
        cyc; smp;
        checks++; if ({bready_o, awvalid_o, wvalid_o, rsp_valid, rsp_resp, rsp_id, rsp_data} !== {4'b0001, 2'b11, 4'd3, 32'd0}) begin
            failures++; $display("FAIL to_abort got=%h exp=%h", {bready_o, awvalid_o, wvalid_o, rsp_valid, rsp_resp, rsp_id, rsp_data}, {4'b0001, 2'b11, 4'd3, 32'd0}); end
        b0 = b_hs;
        cyc; bvalid_i = 1; bresp_i = 2'b00; smp;
        checks++; if ({rsp_valid, bready_o, rsp_resp} !== 4'b1011) begin
            failures++; $display("FAIL to_stray_rsp got=%b exp=1011", {rsp_valid, bready_o, rsp_resp}); end
        cyc; bvalid_i = 0; rsp_ready = 1; smp;
        cyc; rsp_ready = 0; bvalid_i = 1; smp;
        checks++; if ({cmd_ready, rsp_valid} !== 2'b10 || b_hs != b0 || (rsp_hs - r0) != 1) begin
            failures++; $display("FAIL to_stray_idle got=%b%b b%0d r%0d exp=10 b0 r1", cmd_ready, rsp_valid, b_hs - b0, rsp_hs - r0); end
        cyc; bvalid_i = 0;
    endtask

    // rvalid lands in the very cycle the watchdog expires; the data must win.
    task automatic test_timeout_tie;
        arready_i = 1;
        cyc; send(1'b0, 4'd2, 32'd8, 32'd0, 4'h0); smp;
        cyc; cmd_valid = 0; smp;
        for (int k = 2; k < TO; k++) begin cyc; smp; end
        cyc; rvalid_i = 1; rdata_i = 32'h0BADF00D; smp;
        checks++; if ({rready_o, rsp_valid} !== 2'b10) begin failures++; $display("FAIL tie_c8 got=%b exp=10", {rready_o, rsp_valid}); end
        cyc; rvalid_i = 0; rdata_i = 0; rsp_ready = 1; smp;
        checks++; if ({rsp_valid, rsp_resp, rsp_data} !== {1'b1, 2'b00, 32'h0BADF00D}) begin
            failures++; $display("FAIL tie_rsp got=%h exp=%h", {rsp_valid, rsp_resp, rsp_data}, {1'b1, 2'b00, 32'h0BADF00D}); end
        cyc; rsp_ready = 0;
    endtask

    task automatic test_reset_mid;
        int r0;
        logic got;
        arready_i = 1;
        cyc; send(1'b0, 4'd4, 32'hC, 32'd0, 4'h0); smp;
        cyc; cmd_valid = 0; smp;
        cyc; smp;
        checks++; if (rready_o !== 1'b1) begin failures++; $display("FAIL mid_rd_data got=%b exp=1", rready_o); end
        r0 = rsp_hs;
        cyc; areset = 1; smp;
        cyc; areset = 0; smp;
        checks++; if ({awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid, cmd_ready, rsp_id} !== {7'b0000001, 4'd0}) begin
            failures++; $display("FAIL mid_reset got=%h exp=%h", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, rsp_valid, cmd_ready, rsp_id}, {7'b0000001, 4'd0}); end
        cyc; send(1'b1, 4'hA, 32'h20, 32'hCAFEF00D, 4'hC); awready_i = 1; wready_i = 1; smp;
        cyc; cmd_valid = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            bvalid_i = bready_o; bresp_i = 2'b00; smp;
            if (rsp_valid) got = 1'b1; else cyc;
        end
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL mid_wr_timeout got=no_rsp exp=rsp_valid"); end
        checks++; if ({rsp_write, rsp_id, rsp_resp} !== {1'b1, 4'hA, 2'b00}) begin
            failures++; $display("FAIL mid_wr_rsp got=%h exp=%h", {rsp_write, rsp_id, rsp_resp}, {1'b1, 4'hA, 2'b00}); end
        cyc; bvalid_i = 0; rsp_ready = 1;
        cyc; rsp_ready = 0; smp;
        checks++; if ((rsp_hs - r0) != 1 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL mid_rsp_count got=%0d/%b exp=1/1", rsp_hs - r0, cmd_ready); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_skewed_write;
        test_read;
        test_backpressure;
        test_timeout;
        test_timeout_tie;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=running exp=finished");
        $fatal(1, "time limit");
    end
endmodule
